// File: rtl/uart_byte_tx.sv
// -----------------------------------------------------------------------------
// uart_byte_tx
//   Transmit half of the board UART link. Each accepted request is sent as one
//   frame on Rs232_Tx: a start bit, 8 data bits LSB first, one check bit, and
//   STOP_BITS stop bits. Bit timing comes from the same baud_set table and
//   16x-tick timebase as the receive side, so the two agree on bit period.
//
// Parameters
//   PARITY_ODD  0: check bit = ^data (even), 1: check bit = ~^data (odd)
//   STOP_BITS   number of stop bits, 1 or 2
//
// Ports
//   Clk         system clock (50 MHz nominal)
//   Rst_n       asynchronous active-low reset
//   baud_set    rate select 0:9600 1:19200 2:38400 3:57600 4:115200, else 9600
//   Send_En     single-cycle send request, honoured only while idle
//   data_byte   byte to send, captured on the accepting edge
//   Rs232_Tx    serial line, idle high, registered
//   Tx_Done     one-cycle pulse in the last clock of the final stop bit
//   uart_state  1 while a frame is in progress
// -----------------------------------------------------------------------------
module uart_byte_tx #(
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] baud_set,
  input  logic       Send_En,
  input  logic [7:0] data_byte,
  output logic       Rs232_Tx,
  output logic       Tx_Done,
  output logic       uart_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Frame position of the final stop bit (0 = start bit).
  localparam logic [3:0] LAST_BIT = 4'(9 + STOP_BITS);

  logic [2:0]  r_state;
  logic [15:0] r_bps_dr;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_tick_cnt;
  logic [3:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_parity;
  logic        r_busy;
  logic        r_tx;
  logic        r_done;

  logic [15:0] w_bps_dr;
  logic        w_parity;
  logic        w_accept;
  logic        w_tick;
  logic        w_bit_end;
  logic        w_last;
  logic        w_line;

  // Prescaler terminal count for 16 ticks per bit at 50 MHz.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    w_bps_dr = 16'd324;
    case (baud_set)
      3'd0:    w_bps_dr = 16'd324;
      3'd1:    w_bps_dr = 16'd162;
      3'd2:    w_bps_dr = 16'd80;
      3'd3:    w_bps_dr = 16'd53;
      3'd4:    w_bps_dr = 16'd26;
      default: w_bps_dr = 16'd324;
    endcase
  end

  assign w_parity  = (PARITY_ODD != 0) ? ~^data_byte : ^data_byte;
  assign w_accept  = Send_En & ~r_busy;
  assign w_tick    = r_busy & (r_div_cnt == r_bps_dr);
  assign w_bit_end = w_tick & (r_tick_cnt == 4'd15);
  assign w_last    = w_bit_end & (r_bit_idx == LAST_BIT);

  // Level for the bit currently being timed; registered into r_tx so the line
  // lags the counters by one clock and the start bit appears one clock after
  // the accepting edge.
  always_comb begin
    w_line = 1'b1;
    if (r_busy) begin
      case (r_state)
        S_START:  w_line = 1'b0;
        S_DATA:   w_line = r_shift[0];
        S_PARITY: w_line = r_parity;
        default:  w_line = 1'b1;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state    <= S_IDLE;
      r_bps_dr   <= 16'd0;
      r_div_cnt  <= 16'd0;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 4'd0;
      r_shift    <= 8'd0;
      r_parity   <= 1'b0;
      r_busy     <= 1'b0;
    end else if (w_accept) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state    <= S_START;
      r_bps_dr   <= w_bps_dr;
      r_div_cnt  <= 16'd0;
      r_tick_cnt <= 4'd0;
      r_bit_idx  <= 4'd0;
      r_shift    <= data_byte;
      r_parity   <= w_parity;
      r_busy     <= 1'b1;
    end else if (r_busy) begin
      r_div_cnt <= w_tick ? 16'd0 : r_div_cnt + 16'd1;
      if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + 4'd1;  // wraps 15 -> 0 at each bit end
      end
      if (w_last) begin
        r_state   <= S_IDLE;
        r_bit_idx <= 4'd0;
        r_busy    <= 1'b0;
      end else if (w_bit_end) begin
        r_bit_idx <= r_bit_idx + 4'd1;
        case (r_state)
          S_START:  r_state <= S_DATA;
          S_DATA: begin
            if (r_bit_idx == 4'd8) begin
              r_state <= S_PARITY;
            end else begin
              r_shift <= r_shift >> 1;     // next data bit into position 0
            end
          end
          S_PARITY: r_state <= S_STOP;
          default:  r_state <= S_STOP;     // extra stop bits stay in STOP
        endcase
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_tx   <= 1'b1;
      r_done <= 1'b0;
    end else begin
      r_tx   <= w_line;
      r_done <= w_last;
    end
  end

  assign Rs232_Tx   = r_tx;
  assign Tx_Done    = r_done;
  assign uart_state = r_busy;

endmodule
